// File: rtl/operand_issuer_pkg.sv
// Shared types and constants for the operand issuer: FSM state encoding,
// issue counter ceiling and gap counter width.
`timescale 1ns/1ps
package operand_issuer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAPW  = 2'd2
    } state_t;

    localparam logic [7:0] ISSUE_CNT_MAX = 8'd255;
    localparam int         GAP_CW        = 4;

endpackage

// File: rtl/operand_issuer_fifo.sv
// Operand-pair FIFO: power-of-two depth, wrap-around pointers, registered
// occupancy, combinational head read, no bypass path.
`timescale 1ns/1ps
module operand_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push,
    input  logic [2*W-1:0] wr_data,
    input  logic           pop,
    output logic [2*W-1:0] rd_data,
    output logic [LW-1:0]  level
);

    logic [2*W-1:0] mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    // NOTE: storage is left unreset; level and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level + LW'(push) - LW'(pop);
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/operand_issuer.sv
// Operand issuer: queues operand pairs and issues them to the adder stage
// as one-cycle start pulses spaced by at least GAP idle cycles.
`timescale 1ns/1ps
module operand_issuer
    import operand_issuer_pkg::*;
#(
    parameter int W     = 12,
    parameter int DEPTH = 4,
    parameter int GAP   = 2,
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    input  logic          hold,
    output logic          start,
    output logic [W-1:0]  a,
    output logic [W-1:0]  b,
    output logic          busy,
    output logic [LW-1:0] level,
    output logic [7:0]    issue_cnt
);

    state_t              state;
    state_t              state_nx;
    logic [GAP_CW-1:0]   gap_cnt;
    logic                accept;
    logic                issue_now;
    logic [2*W-1:0]      head;

    assign in_ready = (level != LW'(DEPTH));
    assign accept   = in_valid && in_ready;

    operand_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (accept),
        .wr_data ({in_a, in_b}),
        .pop     (issue_now),
        .rd_data (head),
        .level   (level)
    );

    // The pop happens on the edge that enters ISSUE, so start, a and b line up.
    always_comb begin
        state_nx  = state;
        issue_now = 1'b0;
        case (state)
            IDLE: begin
                if (level != '0 && !hold) begin
                    state_nx  = ISSUE;
                    issue_now = 1'b1;
                end
            end
            ISSUE: begin
                if (GAP > 0) begin
                    state_nx = GAPW;
                end else if (level != '0 && !hold) begin
                    state_nx  = ISSUE;
                    issue_now = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            GAPW: begin
                // Leave once the decrement brings the counter down to 1.
                if (gap_cnt <= GAP_CW'(2)) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            gap_cnt   <= '0;
            a         <= '0;
            b         <= '0;
            issue_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == ISSUE && state_nx == GAPW) begin
                gap_cnt <= GAP_CW'(GAP);
            end else if (state == GAPW) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
            if (issue_now) begin
                {a, b} <= head;
                if (issue_cnt != ISSUE_CNT_MAX) begin
                    issue_cnt <= issue_cnt + 8'd1;
                end
            end
        end
    end

    assign start = (state == ISSUE);
    assign busy  = (level != '0) || (state != IDLE);

endmodule

// File: tb/tb_operand_issuer.sv
// Self-checking bench for operand_issuer: two instances (GAP=2 and GAP=0)
// share stimulus; a scoreboard queue checks issued pairs in FIFO order.
`timescale 1ns/1ps
module tb_operand_issuer;

    localparam int W     = 12;
    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          hold = 1'b0;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;

    logic          rdy2, start2, busy2;
    logic [W-1:0]  a2, b2;
    logic [LW-1:0] level2;
    logic [7:0]    cnt2;

    logic          rdy0, start0, busy0;
    logic [W-1:0]  a0, b0;
    logic [LW-1:0] level0;
    logic [7:0]    cnt0;

    operand_issuer #(.W(W), .DEPTH(DEPTH), .GAP(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
        .in_a(in_a), .in_b(in_b), .hold(hold), .start(start2),
        .a(a2), .b(b2), .busy(busy2), .level(level2), .issue_cnt(cnt2)
    );

    operand_issuer #(.W(W), .DEPTH(DEPTH), .GAP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
        .in_a(in_a), .in_b(in_b), .hold(hold), .start(start0),
        .a(a0), .b(b0), .busy(busy0), .level(level0), .issue_cnt(cnt0)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int sel    = 0;

    logic [2*W-1:0] sb[$];
    int             start_cyc[$];
    logic [2*W-1:0] exp_pair;

    logic          m_start, m_rdy, m_busy;
    logic [W-1:0]  m_a, m_b;

    always @(posedge clk) cyc++;

    always_comb begin
        m_start = (sel == 1) ? start0 : start2;
        m_rdy   = (sel == 1) ? rdy0   : rdy2;
        m_busy  = (sel == 1) ? busy0  : busy2;
        m_a     = (sel == 1) ? a0     : a2;
        m_b     = (sel == 1) ? b0     : b2;
    end

    // Scoreboard monitor: every start pulse must present the oldest queued pair.
    always @(negedge clk) begin
        if (m_start) begin
            start_cyc.push_back(cyc);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_start: got a=%h b=%h rdy=%0b busy=%0b, nothing queued",
                         m_a, m_b, m_rdy, m_busy);
            end else begin
                exp_pair = sb.pop_front();
                if ({m_a, m_b} !== exp_pair) begin
                    errors++;
                    $display("FAIL issue_order: got a=%h b=%h expected a=%h b=%h",
                             m_a, m_b, exp_pair[2*W-1:W], exp_pair[W-1:0]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        hold     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        start_cyc.delete();
    endtask

    task automatic drive_pair(input logic [W-1:0] pa, input logic [W-1:0] pb, input bit expect_accept);
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = pa;
        in_b     = pb;
        if (expect_accept) sb.push_back({pa, pb});
    endtask

    task automatic end_drive();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check_spacing(input string name, input int n_exp, input int gap_exp);
        checks++;
        if (start_cyc.size() != n_exp) begin
            errors++;
            $display("FAIL %s_count: got %0d starts expected %0d", name, start_cyc.size(), n_exp);
        end else begin
            for (int i = 1; i < n_exp; i++) begin
                checks++;
                if (start_cyc[i] - start_cyc[i-1] != gap_exp) begin
                    errors++;
                    $display("FAIL %s_spacing[%0d]: got %0d cycles expected %0d",
                             name, i, start_cyc[i] - start_cyc[i-1], gap_exp);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d pairs left expected 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        sel = 0;
        do_reset();
        checks++;
        if ({start2, busy2, rdy2} !== 3'b001) begin
            errors++;
            $display("FAIL reset_flags: got start/busy/ready=%b expected 001", {start2, busy2, rdy2});
        end
        checks++;
        if (level2 !== 3'd0 || cnt2 !== 8'd0) begin
            errors++;
            $display("FAIL reset_counts: got level=%0d issue_cnt=%0d expected 0/0", level2, cnt2);
        end
        checks++;
        if (a2 !== 12'h000 || b2 !== 12'h000) begin
            errors++;
            $display("FAIL reset_operands: got a=%h b=%h expected 000/000", a2, b2);
        end
        checks++;
        if (level0 !== 3'd0 || rdy0 !== 1'b1) begin
            errors++;
            $display("FAIL reset_gap0: got level=%0d ready=%0b expected 0/1", level0, rdy0);
        end
    endtask

    task automatic test_single();
        sel = 0;
        do_reset();
        drive_pair(12'h00A, 12'h005, 1'b1);
        end_drive();
        checks++;
        if (start2 !== 1'b0 || level2 !== 3'd1) begin
            errors++;
            $display("FAIL single_after_accept: got start=%0b level=%0d expected 0/1", start2, level2);
        end
        @(negedge clk);
        checks++;
        if (start2 !== 1'b1 || a2 !== 12'h00A || b2 !== 12'h005 || cnt2 !== 8'd1) begin
            errors++;
            $display("FAIL single_issue: got start=%0b a=%h b=%h cnt=%0d expected 1/00a/005/1",
                     start2, a2, b2, cnt2);
        end
        wait_cycles(4);
        checks++;
        if (start2 !== 1'b0 || a2 !== 12'h00A || b2 !== 12'h005 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL single_hold_values: got start=%0b a=%h b=%h busy=%0b expected 0/00a/005/0",
                     start2, a2, b2, busy2);
        end
        check_spacing("single", 1, 0);
    endtask

    task automatic test_gap_spacing();
        logic [LW-1:0] exp_lvl [3] = '{3'd0, 3'd1, 3'd1};
        sel = 0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (level2 !== exp_lvl[i]) begin
                    errors++;
                    $display("FAIL gap_level[%0d]: got %0d expected %0d", i, level2, exp_lvl[i]);
                end
            end
            in_valid = 1'b1;
            in_a     = 12'h100 + 12'(i);
            in_b     = 12'h200 + 12'(i);
            sb.push_back({in_a, in_b});
        end
        end_drive();
        checks++;
        if (level2 !== 3'd2) begin
            errors++;
            $display("FAIL gap_level_end: got %0d expected 2", level2);
        end
        wait_cycles(12);
        check_spacing("gap", 3, 3);
    endtask

    task automatic test_full_hold();
        sel = 0;
        do_reset();
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 4) begin
                checks++;
                if (rdy2 !== 1'b0) begin
                    errors++;
                    $display("FAIL full_ready: got %0b expected 0", rdy2);
                end
            end
            in_valid = 1'b1;
            in_a     = 12'hA00 + 12'(i);
            in_b     = 12'h0B0 + 12'(i);
            if (i < 4) sb.push_back({in_a, in_b});
        end
        end_drive();
        wait_cycles(2);
        checks++;
        if (level2 !== 3'd4 || rdy2 !== 1'b0 || start2 !== 1'b0 || busy2 !== 1'b1 || cnt2 !== 8'd0) begin
            errors++;
            $display("FAIL full_frozen: got level=%0d ready=%0b start=%0b busy=%0b cnt=%0d expected 4/0/0/1/0",
                     level2, rdy2, start2, busy2, cnt2);
        end
        @(negedge clk);
        hold = 1'b0;
        start_cyc.delete();
        #1;
        checks++;
        if (rdy2 !== 1'b0) begin
            errors++;
            $display("FAIL full_pop_ready: got %0b expected 0", rdy2);
        end
        wait_cycles(14);
        check_spacing("full", 4, 3);
        checks++;
        if (cnt2 !== 8'd4) begin
            errors++;
            $display("FAIL full_count: got %0d expected 4", cnt2);
        end
    endtask

    task automatic test_back_to_back();
        sel = 1;
        do_reset();
        hold = 1'b1;
        for (int i = 0; i < 4; i++) drive_pair(12'h300 + 12'(i), 12'h030 + 12'(i), 1'b1);
        end_drive();
        checks++;
        if (level0 !== 3'd4) begin
            errors++;
            $display("FAIL b2b_level_full: got %0d expected 4", level0);
        end
        hold = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (start0 !== 1'b1 || level0 !== LW'(3 - k)) begin
                errors++;
                $display("FAIL b2b_step[%0d]: got start=%0b level=%0d expected 1/%0d", k, start0, level0, 3 - k);
            end
        end
        @(negedge clk);
        checks++;
        if (start0 !== 1'b0 || cnt0 !== 8'd4) begin
            errors++;
            $display("FAIL b2b_end: got start=%0b cnt=%0d expected 0/4", start0, cnt0);
        end
        check_spacing("b2b", 4, 1);
        sel = 0;
    endtask

    task automatic test_saturation();
        sel = 0;
        do_reset();
        for (int i = 0; i < 260; i++) begin
            drive_pair(12'(i), ~12'(i), 1'b1);
            end_drive();
            @(negedge clk);
            if (i == 253 || i == 254 || i == 259) begin
                checks++;
                if (cnt2 !== ((i == 253) ? 8'd254 : 8'd255)) begin
                    errors++;
                    $display("FAIL sat_count[%0d]: got %0d expected %0d", i, cnt2, (i == 253) ? 254 : 255);
                end
            end
        end
        wait_cycles(3);
        check_spacing("sat", 260, 3);
    endtask

    task automatic test_reset_mid_gap();
        sel = 0;
        do_reset();
        hold = 1'b1;
        for (int i = 0; i < 4; i++) drive_pair(12'h5A0 + 12'(i), 12'h0C0 + 12'(i), 1'b1);
        end_drive();
        hold = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (level2 !== 3'd3 || start2 !== 1'b0 || busy2 !== 1'b1) begin
            errors++;
            $display("FAIL midgap_pre: got level=%0d start=%0b busy=%0b expected 3/0/1", level2, start2, busy2);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        start_cyc.delete();
        checks++;
        if (level2 !== 3'd0 || start2 !== 1'b0 || busy2 !== 1'b0 || cnt2 !== 8'd0 || rdy2 !== 1'b1) begin
            errors++;
            $display("FAIL midgap_reset: got level=%0d start=%0b busy=%0b cnt=%0d ready=%0b expected 0/0/0/0/1",
                     level2, start2, busy2, cnt2, rdy2);
        end
        drive_pair(12'h3C3, 12'h0F0, 1'b1);
        end_drive();
        @(negedge clk);
        checks++;
        if (start2 !== 1'b1 || cnt2 !== 8'd1) begin
            errors++;
            $display("FAIL midgap_reissue: got start=%0b cnt=%0d expected 1/1", start2, cnt2);
        end
        wait_cycles(3);
        check_spacing("midgap", 1, 0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_gap_spacing();
        test_full_hold();
        test_back_to_back();
        test_saturation();
        test_reset_mid_gap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
